// File: rtl/key_event_scan.sv
// rtl/key_event_scan.sv - synchronised, debounced active-low keys with a single-slot press-event output
// Optional auto-repeat of held keys is built when KEY_REPEAT_EN is defined.
module key_event_scan #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                                        clk_50M,
    input  logic                                        rst_n,
    input  logic [N_KEYS-1:0]                           key_n,
    output logic [N_KEYS-1:0]                           key_state,
    output logic                                        evt_valid,
    input  logic                                        evt_ready,
    output logic [((N_KEYS > 1) ? $clog2(N_KEYS) : 1)-1:0] evt_key,
    output logic                                        evt_rpt,
    output logic                                        evt_ovf
);

    localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_t;

    logic [N_KEYS-1:0] sync_q1;
    logic [N_KEYS-1:0] sync_q2;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] differ;
    logic [N_KEYS-1:0] at_end;
    logic [N_KEYS-1:0] press_flip;
    logic [N_KEYS-1:0] release_flip;
    logic [N_KEYS-1:0] rpt_fire;
    logic [N_KEYS-1:0] new_evt;
    logic [N_KEYS-1:0] db_state;
    logic [CW-1:0]     db_cnt [N_KEYS];

    slot_t             slot_q;
    slot_t             slot_d;
    logic [N_KEYS-1:0] pending_q;
    logic [N_KEYS-1:0] pending_d;
    logic [N_KEYS-1:0] take_mask;
    logic [N_KEYS-1:0] accept;
    logic              take;
    logic              ovf_d;
    logic [KW-1:0]     sel;
    logic [KW-1:0]     evt_key_q;
    logic              evt_ovf_q;

    // Synchronisers idle at 1 so a key held through reset looks like a fresh press.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    assign level = ~sync_q2;

    always_comb begin
        differ = level ^ db_state;
        at_end = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            at_end[i] = (db_cnt[i] == CNT_END);
        end
        press_flip   = differ & at_end & level;
        release_flip = differ & at_end & ~level;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            db_state <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (!differ[i]) begin
                    db_cnt[i] <= '0;
                end else if (at_end[i]) begin
                    db_cnt[i]   <= '0;
                    db_state[i] <= level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign new_evt = press_flip | rpt_fire;

    // Lowest-index pending key wins the slot.
    always_comb begin
        sel = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = KW'(i);
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        take   = 1'b0;
        if ((|pending_q) && (slot_q == SLOT_EMPTY || evt_ready)) begin
            take   = 1'b1;
            slot_d = SLOT_FULL;
        end else if (slot_q == SLOT_FULL && evt_ready) begin
            slot_d = SLOT_EMPTY;
        end
    end

    // A pending bit being drained this edge is free to take a new event.
    always_comb begin
        take_mask = '0;
        if (take) begin
            take_mask[sel] = 1'b1;
        end
        accept    = new_evt & ~(pending_q & ~take_mask);
        ovf_d     = |(new_evt & pending_q & ~take_mask);
        pending_d = (pending_q & ~take_mask) | accept;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= SLOT_EMPTY;
            pending_q <= '0;
            evt_key_q <= '0;
            evt_ovf_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            pending_q <= pending_d;
            evt_ovf_q <= evt_ovf_q | ovf_d;
            if (take) begin
                evt_key_q <= sel;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] DELAY_END = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_END  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0]     rpt_cnt [N_KEYS];
    logic [N_KEYS-1:0] rpt_first;
    logic [N_KEYS-1:0] pend_rpt_q;
    logic              evt_rpt_q;

    // No repeat on the edge where the key is being released.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            rpt_fire[i] = db_state[i] && !release_flip[i] &&
                          (rpt_cnt[i] == (rpt_first[i] ? DELAY_END : RATE_END));
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rpt_first  <= '1;
            pend_rpt_q <= '0;
            evt_rpt_q  <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (!db_state[i] || release_flip[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b1;
                end else if (rpt_fire[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
                if (accept[i]) begin
                    pend_rpt_q[i] <= rpt_fire[i];
                end
            end
            if (take) begin
                evt_rpt_q <= pend_rpt_q[sel];
            end
        end
    end

    assign evt_rpt = evt_rpt_q;
`else
    assign rpt_fire = '0;
    assign evt_rpt  = 1'b0;
`endif

    assign key_state = db_state;
    assign evt_valid = (slot_q == SLOT_FULL);
    assign evt_key   = evt_key_q;
    assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_key_event_scan.sv
// tb/tb_key_event_scan.sv - directed and randomised bench for key_event_scan against a behavioural model
module tb_key_event_scan;

    localparam int N     = 4;
    localparam int DEB   = 8;
    localparam int RDLY  = 20;
    localparam int RRATE = 6;
`ifdef KEY_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic         clk_50M = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_n;
    logic [N-1:0] key_state;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_key;
    logic         evt_rpt;
    logic         evt_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    int hs_rpt   = 0;

    always #10 clk_50M = ~clk_50M;

    key_event_scan #(
        .N_KEYS      (N),
        .DEBOUNCE_CYC(DEB),
        .REPEAT_DELAY(RDLY),
        .REPEAT_RATE (RRATE)
    ) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key  (evt_key),
        .evt_rpt  (evt_rpt),
        .evt_ovf  (evt_ovf)
    );

    // Behavioural model: pressed level seen through a two-sample delay, a key flips
    // after DEB consecutive differing samples, events queue one per key behind one slot.
    bit m_d1 [N];
    bit m_d2 [N];
    bit m_st [N];
    int m_run [N];
    int m_hold [N];
    bit m_pend [N];
    bit m_pend_r [N];
    bit m_valid;
    bit m_rpt;
    bit m_ovf;
    int m_key;
    bit ev [N];
    bit evr [N];
    bit old_st;
    bit flip;
    bit found;

    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_d1[i] = 0; m_d2[i] = 0; m_st[i] = 0; m_run[i] = 0;
                m_hold[i] = 0; m_pend[i] = 0; m_pend_r[i] = 0;
            end
            m_valid = 0; m_rpt = 0; m_ovf = 0; m_key = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                ev[i] = 0; evr[i] = 0;
                old_st = m_st[i];
                flip = 0;
                if (m_d2[i] != old_st) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        flip = 1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (flip) m_st[i] = !old_st;
                if (flip && !old_st) ev[i] = 1;
                if (RPT_EN && old_st && !flip) begin
                    m_hold[i]++;
                    if (m_hold[i] == RDLY || (m_hold[i] > RDLY && (m_hold[i] - RDLY) % RRATE == 0)) begin
                        ev[i] = 1; evr[i] = 1;
                    end
                end else begin
                    m_hold[i] = 0;
                end
            end
            if (!m_valid || evt_ready) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && !found) begin
                        found = 1; m_key = i; m_rpt = m_pend_r[i]; m_pend[i] = 0;
                    end
                end
                m_valid = found;
            end
            for (int i = 0; i < N; i++) begin
                if (ev[i]) begin
                    if (m_pend[i]) m_ovf = 1;
                    else begin
                        m_pend[i] = 1; m_pend_r[i] = evr[i];
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                m_d2[i] = m_d1[i];
                m_d1[i] = !key_n[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] st;
        for (int i = 0; i < N; i++) st[i] = m_st[i];
        chk("key_state", 32'(key_state), 32'(st));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) begin
            chk("evt_key", 32'(evt_key), 32'(m_key));
            chk("evt_rpt", 32'(evt_rpt), 32'(m_rpt));
        end
        chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
    endtask

    task automatic tick();
        if (rst_n && evt_valid && evt_ready) begin
            hs_cnt++;
            if (evt_rpt) hs_rpt++;
        end
        @(posedge clk_50M);
        @(negedge clk_50M);
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = '1;
        evt_ready = 1'b1;
        tick();
        tick();
        chk("rst_key_state", 32'(key_state), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ovf", 32'(evt_ovf), 0);
        rst_n = 1'b1;
        idle(4);

        // clean press and release of key 2
        key_n[2] = 1'b0;
        idle(9);
        chk("press_state_e9", 32'(key_state[2]), 0);
        tick();
        chk("press_state_e10", 32'(key_state[2]), 1);
        chk("press_valid_e10", 32'(evt_valid), 0);
        tick();
        chk("press_valid_e11", 32'(evt_valid), 1);
        chk("press_key_e11", 32'(evt_key), 2);
        tick();
        chk("press_valid_e12", 32'(evt_valid), 0);
        key_n[2] = 1'b1;
        idle(9);
        chk("release_state_e9", 32'(key_state[2]), 1);
        tick();
        chk("release_state_e10", 32'(key_state[2]), 0);
        chk("release_no_evt", 32'(evt_valid), 0);
        idle(4);

        // bounce on key 0
        hs_cnt = 0;
        key_n[0] = 1'b0;
        idle(5);
        key_n[0] = 1'b1;
        tick();
        key_n[0] = 1'b0;
        idle(10);
        chk("bounce_valid_e10", 32'(evt_valid), 0);
        tick();
        chk("bounce_valid_e11", 32'(evt_valid), 1);
        chk("bounce_key", 32'(evt_key), 0);
        idle(5);
        chk("bounce_events", 32'(hs_cnt), 1);
        key_n[0] = 1'b1;
        idle(12);

        // simultaneous press of keys 1 and 3 with the consumer stalled
        evt_ready = 1'b0;
        key_n[1] = 1'b0;
        key_n[3] = 1'b0;
        idle(11);
        chk("simul_valid", 32'(evt_valid), 1);
        chk("simul_key_first", 32'(evt_key), 1);
        idle(4);
        chk("simul_key_held", 32'(evt_key), 1);
        hs_cnt = 0;
        evt_ready = 1'b1;
        tick();
        chk("simul_reload_valid", 32'(evt_valid), 1);
        chk("simul_key_second", 32'(evt_key), 3);
        tick();
        chk("simul_drained", 32'(evt_valid), 0);
        chk("simul_events", 32'(hs_cnt), 2);
        key_n[1] = 1'b1;
        key_n[3] = 1'b1;
        idle(12);

        // overflow on key 0: slot and pending occupied, third press dropped
        evt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            key_n[0] = 1'b0;
            idle(12);
            if (p == 1) chk("ovf_not_yet", 32'(evt_ovf), 0);
            if (p < 2) begin
                key_n[0] = 1'b1;
                idle(12);
            end
        end
        chk("ovf_set", 32'(evt_ovf), 1);
        hs_cnt = 0;
        evt_ready = 1'b1;
        idle(5);
        chk("ovf_events", 32'(hs_cnt), 2);
        chk("ovf_sticky", 32'(evt_ovf), 1);
        key_n[0] = 1'b1;
        idle(12);

        // reset in the middle of a debounce with the key held throughout
        key_n[2] = 1'b0;
        idle(5);
        rst_n = 1'b0;
        tick();
        chk("midrst_state", 32'(key_state), 0);
        chk("midrst_valid", 32'(evt_valid), 0);
        chk("midrst_key", 32'(evt_key), 0);
        chk("midrst_rpt", 32'(evt_rpt), 0);
        chk("midrst_ovf", 32'(evt_ovf), 0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        chk("midrst_valid_e10", 32'(evt_valid), 0);
        tick();
        chk("midrst_valid_e11", 32'(evt_valid), 1);
        chk("midrst_key_e11", 32'(evt_key), 2);
        key_n[2] = 1'b1;
        idle(12);

        if (RPT_EN) begin
            key_n[1] = 1'b0;
            idle(10);
            chk("rpt_state_up", 32'(key_state[1]), 1);
            hs_cnt = 0;
            hs_rpt = 0;
            idle(34);
            chk("rpt_events", 32'(hs_cnt), 4);
            chk("rpt_repeats", 32'(hs_rpt), 3);
            key_n[1] = 1'b1;
            idle(12);
            hs_rpt = 0;
            idle(30);
            chk("rpt_stopped", 32'(hs_rpt), 0);
        end

        // randomised keys, consumer back-pressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 29) == 0) key_n[i] = ~key_n[i];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
